// File: rtl/seq_mult_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared definitions for the sequential shift-add multiplier.
//                Holds the FSM state encodings and the ceiling-log2 helper
//                used to size the step counter.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_mult_pkg;

  // FSM state encodings (single-bit state register)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ceiling log2 with a floor of 1 so that a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >>> 1;
      end
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_param_step.sv
`default_nettype none
// ============================================================================
//  Module      : mult_addsub_step
//  Description : One combinational add/subtract step of the shift-add
//                multiplier. Conditionally adds (or subtracts, for the
//                negatively weighted signed MSB) the extended multiplicand
//                to the accumulator. The shift is done by the caller.
//  Ports       : acc       in  N+1  current accumulator
//                mcand_ext in  N+1  sign- or zero-extended multiplicand
//                m         in  1    current multiplier bit
//                sub       in  1    1 = subtract instead of add
//                acc_next  out N+1  accumulator after add/sub, before shift
//  Revision    : 1.0  initial release
// ============================================================================
module mult_addsub_step #(
  parameter int N = 6
) (
  input  logic [N:0] acc,
  input  logic [N:0] mcand_ext,
  input  logic       m,
  input  logic       sub,
  output logic [N:0] acc_next
);

  logic [N:0] addend;

  always_comb begin
    addend = m ? mcand_ext : '0;
    if (sub) begin
      acc_next = acc - addend;
    end else begin
      acc_next = acc + addend;
    end
  end

endmodule : mult_addsub_step
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_param
//  Description : Parametrised sequential shift-add multiplier producing one
//                2N-bit product every N step cycles. Unsigned or two's-
//                complement operation is selected per run via is_signed.
//  Ports       : clk       in  1   rising-edge clock
//                rst       in  1   asynchronous active-low reset
//                load      in  1   start request (accepted when not busy)
//                is_signed in  1   1 = signed operands, sampled with load
//                a         in  N   multiplicand, sampled with load
//                b         in  N   multiplier, sampled with load
//                product   out 2N  last completed product (held)
//                busy      out 1   high while a multiply is running
//                done      out 1   one-cycle pulse when product updates
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           is_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int            CW        = clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  logic [0:0]     state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [N:0]     acc_q,     acc_d;
  logic [N-1:0]   breg_q,    breg_d;
  logic [N:0]     mcand_q,   mcand_d;
  logic           signed_q,  signed_d;
  logic [2*N-1:0] product_q, product_d;
  logic           done_q,    done_d;

  logic           step_sub;
  logic           shift_in;
  logic [N:0]     step_acc;

  // The final step of a signed run carries the negative MSB weight.
  assign step_sub = signed_q && (cnt_q == LAST_STEP);

  mult_addsub_step #(
    .N (N)
  ) u_step (
    .acc       (acc_q),
    .mcand_ext (mcand_q),
    .m         (breg_q[0]),
    .sub       (step_sub),
    .acc_next  (step_acc)
  );

  // Signed: the N+1 bit sum is a proper two's-complement value, so shift in
  // its sign. Unsigned: the sum is a non-negative N+1 bit value whose top
  // bit is magnitude, so the shift must be logical.
  assign shift_in = signed_q ? step_acc[N] : 1'b0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    breg_d    = breg_q;
    mcand_d   = mcand_q;
    signed_d  = signed_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          breg_d   = b;
          mcand_d  = is_signed ? {a[N-1], a} : {1'b0, a};
          signed_d = is_signed;
        end
      end

      ST_RUN: begin
        // {acc, b_reg} shifted right one place after the add/sub step
        acc_d  = {shift_in, step_acc[N:1]};
        breg_d = {step_acc[0], breg_q[N-1:1]};
        if (cnt_q == LAST_STEP) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          product_d = {acc_d[N-1:0], breg_d};
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      breg_q    <= '0;
      mcand_q   <= '0;
      signed_q  <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      breg_q    <= breg_d;
      mcand_q   <= mcand_d;
      signed_q  <= signed_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule : seq_mult_param
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_param
//  Description : Directed self-checking bench for seq_mult_param (N=6) plus
//                a random sweep of an N=8 instance against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_param;

  logic clk;
  logic rst;

  logic        load;
  logic        is_signed;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [11:0] product;
  logic        busy;
  logic        done;

  logic        load8;
  logic        is_signed8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] product8;
  logic        busy8;
  logic        done8;

  int n_checks;
  int n_pass;

  seq_mult_param #(.N(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .product   (product),
    .busy      (busy),
    .done      (done)
  );

  seq_mult_param #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .load      (load8),
    .is_signed (is_signed8),
    .a         (a8),
    .b         (b8),
    .product   (product8),
    .busy      (busy8),
    .done      (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse load for one edge, then wait for done. lat counts edges after the
  // accept edge; busy_cyc counts sampled cycles with busy high before done.
  task automatic run6(input logic [5:0] av, input logic [5:0] bv, input logic sv,
                      output int lat, output int busy_cyc, output bit tmo);
    a = av; b = bv; is_signed = sv; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    lat = 0; busy_cyc = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; load = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    load8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    n_checks++;
    if (product !== 12'h000) $display("FAIL reset_product: got %h expected 000", product);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat, bc; bit tmo;
    run6(6'd29, 6'd13, 1'b0, lat, bc, tmo);
    n_checks++;
    if (tmo || lat != 6) $display("FAIL unsigned_latency: got %0d timeout=%0d expected 6", lat, tmo);
    else n_pass++;
    n_checks++;
    if (bc != 6) $display("FAIL unsigned_busy_cycles: got %0d expected 6", bc);
    else n_pass++;
    n_checks++;
    if (product !== 12'h179) $display("FAIL unsigned_product: got %h expected 179", product);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_in_done_cycle: got %b expected 0", busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done);
    else n_pass++;
  endtask

  task automatic test_signed;
    int lat, bc; bit tmo;
    run6(6'h3D, 6'd5, 1'b1, lat, bc, tmo);
    n_checks++;
    if (tmo || product !== 12'hFF1) $display("FAIL signed_m3x5: got %h expected ff1", product);
    else n_pass++;
    run6(6'h20, 6'h20, 1'b1, lat, bc, tmo);
    n_checks++;
    if (tmo || product !== 12'h400) $display("FAIL signed_m32xm32: got %h expected 400", product);
    else n_pass++;
    run6(6'h3F, 6'h3F, 1'b0, lat, bc, tmo);
    n_checks++;
    if (tmo || product !== 12'hF81) $display("FAIL unsigned_63x63: got %h expected f81", product);
    else n_pass++;
    run6(6'h3F, 6'h3F, 1'b1, lat, bc, tmo);
    n_checks++;
    if (tmo || product !== 12'h001) $display("FAIL signed_m1xm1: got %h expected 001", product);
    else n_pass++;
  endtask

  task automatic test_load_while_busy;
    int lat; int extra_done; bit tmo;
    a = 6'd29; b = 6'd13; is_signed = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin
        a = 6'd1; b = 6'd1; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    load = 1'b0;
    n_checks++;
    if (tmo || lat != 6) $display("FAIL ignore_load_latency: got %0d expected 6", lat);
    else n_pass++;
    n_checks++;
    if (product !== 12'h179) $display("FAIL ignore_load_product: got %h expected 179", product);
    else n_pass++;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    n_checks++;
    if (extra_done != 0) $display("FAIL ignore_load_extra_activity: got %0d cycles expected 0", extra_done);
    else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int stray; int lat, bc; bit tmo;
    a = 6'd7; b = 6'd9; is_signed = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (product !== 12'h000) $display("FAIL async_reset_product: got %h expected 000", product);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", busy);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL reset_no_done: got %0d pulses expected 0", stray);
    else n_pass++;
    run6(6'd5, 6'd6, 1'b0, lat, bc, tmo);
    n_checks++;
    if (tmo || product !== 12'h01E) $display("FAIL post_reset_run: got %h expected 01e", product);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c1, c2, unstable;
    a = 6'd7; b = 6'd9; is_signed = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    a = 6'h3C; b = 6'h3C; is_signed = 1'b1;
    c1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      c1++;
      if (done) break;
    end
    n_checks++;
    if (c1 != 6 || product !== 12'h03F) $display("FAIL b2b_first: got %h after %0d expected 03f after 6", product, c1);
    else n_pass++;
    c2 = 0; unstable = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      c2++;
      if (done) break;
      if (product !== 12'h03F) unstable++;
    end
    load = 1'b0;
    n_checks++;
    if (c2 != 7) $display("FAIL b2b_interval: got %0d expected 7", c2);
    else n_pass++;
    n_checks++;
    if (product !== 12'h010) $display("FAIL b2b_second: got %h expected 010", product);
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL b2b_hold: got %0d unstable cycles expected 0", unstable);
    else n_pass++;
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_stop: got busy %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_random_n8;
    logic [7:0]  av, bv;
    logic        sv;
    logic [15:0] exp;
    int          x, y;
    bit          tmo;
    for (int v = 0; v < 300; v++) begin
      if (v == 0) begin
        av = 8'h80; bv = 8'h80; sv = 1'b1;
      end else if (v == 1) begin
        av = 8'hFF; bv = 8'hFF; sv = 1'b0;
      end else begin
        av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
      end
      x = sv ? int'($signed(av)) : int'(av);
      y = sv ? int'($signed(bv)) : int'(bv);
      exp = 16'(x * y);
      a8 = av; b8 = bv; is_signed8 = sv; load8 = 1'b1;
      @(posedge clk); #1;
      load8 = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done8) begin
          tmo = 1'b0;
          break;
        end
      end
      n_checks++;
      if (tmo || product8 !== exp)
        $display("FAIL n8_random[%0d] a=%h b=%h s=%0d: got %h expected %h timeout=%0d",
                 v, av, bv, sv, product8, exp, tmo);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_load_while_busy();
    test_reset_midrun();
    test_back_to_back();
    test_random_n8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_mult_param
`default_nettype wire
